// File: rtl/char_mem_pkg.sv
// -----------------------------------------------------------------------------
// char_mem_pkg
// Shared constants, FSM state type and glyph bit-ordering helpers for the
// character memory controller.
//
// Bit ordering of a glyph: bit index k walks the 4x5 glyph in raster order,
// left to right then top to bottom. Column x = k % 4, row y = k / 4, and the
// pixel value comes from glyph bit (19 - k), so bit 19 is the top-left pixel.
// -----------------------------------------------------------------------------
package char_mem_pkg;

   localparam int NUM_CHARS  = 36;
   localparam int GLYPH_W    = 4;
   localparam int GLYPH_H    = 5;
   localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;

   localparam int CHAR_W = 6;   // glyph index width
   localparam int K_W    = 5;   // bit counter width (0..19)
   localparam int X_W    = 2;   // column address width
   localparam int Y_W    = 3;   // row address width

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } ld_state_e;

   function automatic logic [X_W-1:0] bit_x(input logic [K_W-1:0] k);
      return X_W'(int'(k) % GLYPH_W);
   endfunction

   function automatic logic [Y_W-1:0] bit_y(input logic [K_W-1:0] k);
      return Y_W'(int'(k) / GLYPH_W);
   endfunction

   function automatic logic [K_W-1:0] bit_idx(input logic [K_W-1:0] k);
      return K_W'(GLYPH_BITS - 1 - int'(k));
   endfunction

endpackage

// File: rtl/char_mem_ctrl_glyph_bit_seq.sv
// -----------------------------------------------------------------------------
// glyph_bit_seq
// Bit sequencer for a glyph load: holds the bit counter k and turns it into
// the array column/row address, the glyph bit to write and a last-bit flag.
//
// Ports:
//   clock    in   system clock
//   rst      in   synchronous, active-high reset
//   clr_i    in   restart the sequence at k = 0 (wins over en_i)
//   en_i     in   advance to the next bit (one array write happened)
//   glyph_i  in   latched 20-bit glyph bitmap, bit 19 = top-left
//   x_o      out  column of bit k
//   y_o      out  row of bit k
//   bit_o    out  pixel value of bit k
//   last_o   out  k is the final bit of the glyph
// -----------------------------------------------------------------------------
module glyph_bit_seq
   import char_mem_pkg::*;
(
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  en_i,
   input  logic [GLYPH_BITS-1:0] glyph_i,
   output logic [X_W-1:0]        x_o,
   output logic [Y_W-1:0]        y_o,
   output logic                  bit_o,
   output logic                  last_o
);

   logic [K_W-1:0] k_q, k_d;

   always_comb begin
      k_d = k_q;
      if (clr_i) begin
         k_d = '0;
      end else if (en_i) begin
         k_d = k_q + K_W'(1);
      end
   end

   // NOTE: sequential state is only ever assigned with <= so every flop
   // samples the values from before the edge, regardless of block order.
   always_ff @(posedge clock) begin
      if (rst) begin
         k_q <= '0;
      end else begin
         k_q <= k_d;
      end
   end

   assign x_o    = bit_x(k_q);
   assign y_o    = bit_y(k_q);
   assign bit_o  = glyph_i[bit_idx(k_q)];
   assign last_o = (k_q == K_W'(GLYPH_BITS - 1));

endmodule

// File: rtl/char_mem_ctrl.sv
// -----------------------------------------------------------------------------
// char_mem_ctrl
// Shares the single x/y/write port of the 36-glyph character array between
// the VGA renderer (one pixel read per cycle, always wins) and a glyph loader
// that rewrites a 4x5 glyph one bit per array write.
//
// Build option:
//   CHAR_MEM_CTRL_BLANK_GATE_EN  when defined, glyph writes only happen while
//                                blank = 1, so a half-written glyph is never
//                                displayed. When undefined, blank is ignored.
//
// Ports:
//   clock, rst      clock, synchronous active-high reset
//   blank           VGA blanking interval indicator
//   rd_req          renderer read request, with rd_char / rd_x / rd_y
//   rd_valid        rd_pixel holds the result of last cycle's read
//   rd_pixel        pixel value, 0 for out-of-range glyph or row
//   ld_valid        glyph load request, with ld_char / ld_glyph
//   ld_ready        controller is idle and can take a load
//   ld_done         one-cycle pulse after the last glyph bit is written
//   ld_err          one-cycle pulse after a load with ld_char >= 36
//   mem_write       array write strobe, with mem_sel (one-hot glyph) / mem_din
//   mem_x, mem_y    array column / row address (read or write)
//   mem_dout        array read data, one bit per glyph
// -----------------------------------------------------------------------------
module char_mem_ctrl
   import char_mem_pkg::*;
#(
   parameter int NUM_CHARS  = char_mem_pkg::NUM_CHARS,
   parameter int GLYPH_BITS = char_mem_pkg::GLYPH_BITS
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  blank,

   input  logic                  rd_req,
   input  logic [CHAR_W-1:0]     rd_char,
   input  logic [X_W-1:0]        rd_x,
   input  logic [Y_W-1:0]        rd_y,
   output logic                  rd_valid,
   output logic                  rd_pixel,

   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [CHAR_W-1:0]     ld_char,
   input  logic [GLYPH_BITS-1:0] ld_glyph,
   output logic                  ld_done,
   output logic                  ld_err,

   output logic                  mem_write,
   output logic [NUM_CHARS-1:0]  mem_sel,
   output logic [X_W-1:0]        mem_x,
   output logic [Y_W-1:0]        mem_y,
   output logic                  mem_din,
   input  logic [NUM_CHARS-1:0]  mem_dout
);

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   ld_state_e               state_q, state_d;
   logic [CHAR_W-1:0]       char_q, char_d;
   logic [GLYPH_BITS-1:0]   glyph_q, glyph_d;
   logic                    ld_done_q, ld_done_d;
   logic                    ld_err_q, ld_err_d;

   logic                    rd_valid_q;
   logic [CHAR_W-1:0]       rd_char_q;
   logic [X_W-1:0]          rd_x_q;
   logic [Y_W-1:0]          rd_y_q;

   // Sequencer interface
   logic                    seq_clr;
   logic [X_W-1:0]          seq_x;
   logic [Y_W-1:0]          seq_y;
   logic                    seq_bit;
   logic                    seq_last;

   logic                    slot_gate;
   logic                    write_slot;
   logic                    ld_char_ok;

   // ---------------------------------------------------------------------------
   // Write-slot qualification: the renderer always owns the port when it asks.
   // ---------------------------------------------------------------------------
`ifdef CHAR_MEM_CTRL_BLANK_GATE_EN
   assign slot_gate = blank;
`else
   assign slot_gate = 1'b1;
`endif

   assign write_slot = (state_q == LOAD) && !rd_req && slot_gate;
   assign ld_char_ok = (int'(ld_char) < NUM_CHARS);

   glyph_bit_seq u_seq (
      .clock   (clock),
      .rst     (rst),
      .clr_i   (seq_clr),
      .en_i    (write_slot),
      .glyph_i (glyph_q),
      .x_o     (seq_x),
      .y_o     (seq_y),
      .bit_o   (seq_bit),
      .last_o  (seq_last)
   );

   // ---------------------------------------------------------------------------
   // Load FSM: next state and handshake
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      char_d    = char_q;
      glyph_d   = glyph_q;
      seq_clr   = 1'b0;
      ld_done_d = 1'b0;
      ld_err_d  = 1'b0;
      ld_ready  = 1'b0;

      case (state_q)
         IDLE: begin
            ld_ready = 1'b1;
            if (ld_valid) begin
               if (ld_char_ok) begin
                  char_d  = ld_char;
                  glyph_d = ld_glyph;
                  seq_clr = 1'b1;
                  state_d = LOAD;
               end else begin
                  ld_err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            // The final write of the glyph frees the controller for the next
            // cycle, so ld_done and ld_ready rise together.
            if (write_slot && seq_last) begin
               ld_done_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q    <= IDLE;
         ld_done_q  <= 1'b0;
         ld_err_q   <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ld_done_q  <= ld_done_d;
         ld_err_q   <= ld_err_d;
         rd_valid_q <= rd_req;
      end
   end

   // NOTE: these hold only payload that is qualified by state or rd_valid, so
   // they are deliberately left out of reset.
   always_ff @(posedge clock) begin
      char_q  <= char_d;
      glyph_q <= glyph_d;
      if (rd_req) begin
         rd_char_q <= rd_char;
         rd_x_q    <= rd_x;
         rd_y_q    <= rd_y;
      end
   end

   // ---------------------------------------------------------------------------
   // Array port mux: read address, glyph write, or parked at zero
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_write = 1'b0;
      mem_sel   = '0;
      mem_x     = '0;
      mem_y     = '0;
      mem_din   = 1'b0;
      if (rd_req) begin
         mem_x = rd_x;
         mem_y = rd_y;
      end else if (write_slot) begin
         mem_write = 1'b1;
         mem_sel   = NUM_CHARS'(1) << char_q;
         mem_x     = seq_x;
         mem_y     = seq_y;
         mem_din   = seq_bit;
      end
   end

   // ---------------------------------------------------------------------------
   // Read return: array data arrives the cycle after the address. An index
   // past the last glyph or a row below the glyph reads as background.
   // ---------------------------------------------------------------------------
   assign rd_valid = rd_valid_q;
   assign rd_pixel = rd_valid_q
                     && (int'(rd_char_q) < NUM_CHARS)
                     && (int'(rd_y_q) < GLYPH_H)
                     && mem_dout[rd_char_q];

   assign ld_done = ld_done_q;
   assign ld_err  = ld_err_q;

   // The column needs no late range check (all four columns exist), and blank
   // is only consulted when write gating is built in.
   logic unused_sig;
   assign unused_sig = ^{rd_x_q, blank};

endmodule

// File: tb/tb_char_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_char_mem_ctrl
// Directed and randomized stimulus for char_mem_ctrl, checked cycle by cycle
// against a transaction-level model: a load is a queue of expected array
// writes built by scanning the glyph bitmap row by row, and a read is a
// one-cycle-delayed lookup into the driven array data.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_char_mem_ctrl;
   import char_mem_pkg::*;

   logic        clock = 1'b0;
   logic        rst;
   logic        blank;
   logic        rd_req;
   logic [5:0]  rd_char;
   logic [1:0]  rd_x;
   logic [2:0]  rd_y;
   logic        rd_valid;
   logic        rd_pixel;
   logic        ld_valid;
   logic        ld_ready;
   logic [5:0]  ld_char;
   logic [19:0] ld_glyph;
   logic        ld_done;
   logic        ld_err;
   logic        mem_write;
   logic [35:0] mem_sel;
   logic [1:0]  mem_x;
   logic [2:0]  mem_y;
   logic        mem_din;
   logic [35:0] mem_dout;

   always #5 clock = ~clock;

   char_mem_ctrl dut (
      .clock     (clock),
      .rst       (rst),
      .blank     (blank),
      .rd_req    (rd_req),
      .rd_char   (rd_char),
      .rd_x      (rd_x),
      .rd_y      (rd_y),
      .rd_valid  (rd_valid),
      .rd_pixel  (rd_pixel),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_char   (ld_char),
      .ld_glyph  (ld_glyph),
      .ld_done   (ld_done),
      .ld_err    (ld_err),
      .mem_write (mem_write),
      .mem_sel   (mem_sel),
      .mem_x     (mem_x),
      .mem_y     (mem_y),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   // ---------------------------------------------------------------------------
   // Counters and reference model state
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [1:0] x;
      logic [2:0] y;
      logic       din;
   } wr_t;

   wr_t         exp_q[$];      // array writes still owed by the current load
   logic [35:0] exp_sel;
   bit          busy;
   bit          exp_done;
   bit          exp_err;
   bit          prev_req;
   logic [5:0]  prev_char;
   logic [2:0]  prev_y;

   // Observations gathered by cycle() for the directed steps
   int  n_writes;
   int  done_cnt;
   int  err_cnt;
   bit  obs_done;
   wr_t first_wr;
   wr_t last_wr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      busy     = 1'b0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      prev_req = 1'b0;
      exp_sel  = '0;
   endtask

   task automatic drive_idle();
      blank    = 1'b1;
      rd_req   = 1'b0;
      rd_char  = '0;
      rd_x     = '0;
      rd_y     = '0;
      ld_valid = 1'b0;
      ld_char  = '0;
      ld_glyph = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clock);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // One clock cycle: inputs are already driven; outputs are checked at the
   // falling edge, then the model advances and the cycle ends 1 ns past the
   // rising edge so the caller can drive the next cycle.
   task automatic cycle();
      bit   slot;
      bit   was_busy;
      logic exp_pix;
      wr_t  e;
      wr_t  w;

      @(negedge clock);

      exp_pix = 1'b0;
      if (prev_req && prev_char < 6'd36 && prev_y < 3'd5) exp_pix = mem_dout[prev_char];
      check("rd_valid", rd_valid, prev_req);
      check("rd_pixel", rd_pixel, exp_pix);
      check("ld_done",  ld_done,  exp_done);
      check("ld_err",   ld_err,   exp_err);
      check("ld_ready", ld_ready, !busy);

      obs_done = (ld_done === 1'b1);
      if (ld_done === 1'b1) done_cnt++;
      if (ld_err === 1'b1)  err_cnt++;

      slot = busy && !rd_req;
`ifdef CHAR_MEM_CTRL_BLANK_GATE_EN
      slot = slot && blank;
`endif

      if (rd_req) begin
         check("rd_mem_write", mem_write, 1'b0);
         check("rd_mem_x", mem_x, rd_x);
         check("rd_mem_y", mem_y, rd_y);
      end else if (slot) begin
         e = exp_q.pop_front();
         check("wr_mem_write", mem_write, 1'b1);
         check("wr_mem_sel", mem_sel, exp_sel);
         check("wr_mem_x", mem_x, e.x);
         check("wr_mem_y", mem_y, e.y);
         check("wr_mem_din", mem_din, e.din);
      end else begin
         check("idle_mem_write", mem_write, 1'b0);
         check("idle_mem_port", {mem_sel, mem_x, mem_y, mem_din}, 42'd0);
      end

      if (mem_write === 1'b1) begin
         w = '{x: mem_x, y: mem_y, din: mem_din};
         if (n_writes == 0) first_wr = w;
         last_wr = w;
         n_writes++;
      end

      was_busy = busy;
      exp_done = slot && (exp_q.size() == 0);
      if (exp_done) busy = 1'b0;
      exp_err = !was_busy && ld_valid && (ld_char >= 6'd36);
      if (!was_busy && ld_valid && ld_char < 6'd36) begin
         busy    = 1'b1;
         exp_sel = 36'd1 << ld_char;
         exp_q.delete();
         for (int row = 0; row < 5; row++) begin
            for (int col = 0; col < 4; col++) begin
               e.x   = 2'(col);
               e.y   = 3'(row);
               e.din = ld_glyph[19 - (row * 4 + col)];
               exp_q.push_back(e);
            end
         end
      end
      prev_req  = rd_req;
      prev_char = rd_char;
      prev_y    = rd_y;

      @(posedge clock);
      #1;
   endtask

   task automatic clear_obs();
      n_writes = 0;
      done_cnt = 0;
      err_cnt  = 0;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int done_at;

      drive_idle();
      mem_dout = '0;
      rst      = 1'b1;
      model_reset();
      clear_obs();
      repeat (2) @(posedge clock);
      #1;
      rst = 1'b0;

      // Reset state and idle behaviour
      check("reset_ld_ready", ld_ready, 1'b1);
      check("reset_outputs", {rd_valid, rd_pixel, ld_done, ld_err, mem_write, mem_sel, mem_x, mem_y, mem_din}, 47'd0);
      repeat (3) cycle();

      // Directed load: glyph F0F0F into glyph 2, every cycle a write slot
      clear_obs();
      ld_valid = 1'b1;
      ld_char  = 6'd2;
      ld_glyph = 20'hF0F0F;
      cycle();
      drive_idle();
      done_at = -1;
      for (int i = 1; i <= 30; i++) begin
         cycle();
         if (obs_done) begin
            done_at = i;
            break;
         end
      end
      check("load_write_count", n_writes, 20);
      check("load_done_cycle", done_at, 21);
      check("load_first_write", first_wr, {2'd0, 3'd0, 1'b1});
      check("load_last_write", last_wr, {2'd3, 3'd4, 1'b1});
      check("load_ready_back", ld_ready, 1'b1);

      // Directed reads
      mem_dout = 36'h20;
      rd_req   = 1'b1;
      rd_char  = 6'd5;
      rd_x     = 2'd1;
      rd_y     = 3'd2;
      cycle();
      rd_req = 1'b0;
      check("read_valid_lat1", rd_valid, 1'b1);
      check("read_pixel_hit", rd_pixel, 1'b1);
      cycle();
      rd_req = 1'b1;
      rd_y   = 3'd6;
      cycle();
      rd_req = 1'b0;
      check("read_row_oob_valid", rd_valid, 1'b1);
      check("read_row_oob_pixel", rd_pixel, 1'b0);
      cycle();

      // Load under alternating renderer reads
      clear_obs();
      ld_valid = 1'b1;
      ld_char  = 6'($urandom_range(0, 35));
      ld_glyph = 20'($urandom());
      rd_req   = 1'b1;
      cycle();
      ld_valid = 1'b0;
      done_at  = -1;
      for (int i = 1; i <= 60; i++) begin
         rd_req   = (i % 2 == 0);
         rd_char  = 6'($urandom_range(0, 39));
         rd_x     = 2'($urandom());
         rd_y     = 3'($urandom_range(0, 7));
         mem_dout = 36'({$urandom(), $urandom()});
         cycle();
         if (obs_done) begin
            done_at = i;
            break;
         end
      end
      drive_idle();
      check("alt_done_cycle", done_at, 40);
      check("alt_write_count", n_writes, 20);

      // Blanking behaviour mid-load
      clear_obs();
      ld_valid = 1'b1;
      ld_char  = 6'd7;
      ld_glyph = 20'($urandom());
      cycle();
      ld_valid = 1'b0;
      repeat (5) cycle();
      blank = 1'b0;
      repeat (10) cycle();
`ifdef CHAR_MEM_CTRL_BLANK_GATE_EN
      check("blank_hold_writes", n_writes, 5);
`else
      check("blank_ignored_writes", n_writes, 15);
`endif
      blank = 1'b1;
      for (int i = 0; i < 30 && busy; i++) cycle();
      cycle();
      check("blank_total_writes", n_writes, 20);
      check("blank_done_count", done_cnt, 1);

      // Rejected load: glyph index out of range
      clear_obs();
      ld_valid = 1'b1;
      ld_char  = 6'd40;
      ld_glyph = 20'hFFFFF;
      cycle();
      ld_valid = 1'b0;
      repeat (4) cycle();
      check("err_pulse_count", err_cnt, 1);
      check("err_no_writes", n_writes, 0);
      check("err_ready_kept", ld_ready, 1'b1);

      // Reset with the sequencer at k = 7
      clear_obs();
      ld_valid = 1'b1;
      ld_char  = 6'd11;
      ld_glyph = 20'($urandom());
      cycle();
      ld_valid = 1'b0;
      repeat (7) cycle();
      check("abort_writes_before_rst", n_writes, 7);
      do_reset();
      clear_obs();
      repeat (25) cycle();
      check("abort_no_done", done_cnt, 0);
      check("abort_no_writes", n_writes, 0);
      check("abort_ready", ld_ready, 1'b1);

      // Randomized traffic
      clear_obs();
      for (int i = 0; i < 600; i++) begin
         rd_req   = ($urandom_range(0, 3) == 0);
         rd_char  = 6'($urandom_range(0, 39));
         rd_x     = 2'($urandom());
         rd_y     = 3'($urandom_range(0, 7));
         blank    = ($urandom_range(0, 3) != 0);
         ld_valid = ($urandom_range(0, 5) == 0);
         ld_char  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(36, 63))
                                                 : 6'($urandom_range(0, 35));
         ld_glyph = 20'($urandom());
         mem_dout = 36'({$urandom(), $urandom()});
         cycle();
      end
      drive_idle();
      for (int i = 0; i < 30 && busy; i++) cycle();
      cycle();
      check("random_drained", busy, 1'b0);
      check("random_ready", ld_ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
